alu_serial_arbiter: RTL and testbench
=====================================

# alu_serial_arbiter

Controller that shares the single serial ALU between two parallel-interface requesters. It arbitrates round-robin and serializes the winner's operands and opcode into the ALU's 10-bit framed serial protocol. It then deserializes the three-word response, checks framing and parity, and returns the result with a one-cycle completion pulse. It sits between the testbench/host command sources and the ALU DUT's `din`/`enable_n`/`dout`/`dout_valid` pins.

## Interface
- `TIMEOUT_CYCLES`, default 256: maximum cycles to wait for `dout_valid` after the command frame.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  2  per-requester request; bit i held high with operands stable until `done[i]`.
- `a0`, `b0`, `op0`  in  8 each  requester 0 operands and opcode.
- `a1`, `b1`, `op1`  in  8 each  requester 1 operands and opcode.
- `done`  out  2  one-hot, one-cycle completion pulse to the served requester.
- `result`  out  16  {data_msb, data_lsb} of the last transaction, held until next `done`.
- `status`  out  8  status byte of the last transaction, held until next `done`.
- `err_parity`  out  1  any response word had bad parity or wrong type bit; valid with `done`.
- `err_timeout`  out  1  no response within `TIMEOUT_CYCLES`; valid with `done`.
- `busy`  out  1  high in every state except IDLE.
- `din`  out  1  serial data to ALU, registered.
- `enable_n`  out  1  active-low frame enable to ALU, registered.
- `dout`  in  1  serial response from ALU.
- `dout_valid`  in  1  ALU response start indicator.

## Operation
- Word format, 10 bits, sent/received MSB first: [9] type (0 = data, 1 = command/status), [8:1] byte, [0] parity = XOR of bits [9:1].
- Command frame is 30 contiguous bits: data word A, data word B, command word op.
- Response is 30 contiguous bits: status word (type 1), data_msb word (type 0), data_lsb word (type 0).
- States are IDLE, SEND, WAIT, RECV and DONE.
- IDLE:
  - If any `req` bit is set, grant one requester and latch its a/b/op, then go to SEND.
  - If both are set, grant the requester not served last. The last-served pointer resets to 1, so requester 0 wins first.
- SEND:
  - Bit counter runs 0..29. `enable_n` is 0 and `din` carries the frame bit.
  - After bit 29, go to WAIT. `dout_valid` is ignored in SEND.
- WAIT:
  - Timeout counter counts from 0. `dout_valid` = 1 goes to RECV, with that same cycle counted as response bit 0.
  - If the counter reaches `TIMEOUT_CYCLES - 1` without `dout_valid`, go to DONE with `err_timeout` = 1, `result` = 0 and `status` = 0.
- RECV:
  - Shift in exactly 30 `dout` samples. `dout_valid` deasserting mid-response is ignored.
  - Check each word's parity and type bit. Any mismatch sets `err_parity`; `result` and `status` are still reported.
- DONE: one cycle. `done[grant]` = 1, outputs update in that cycle, and the pointer records the grant. Next state is IDLE.
- A requester must drop `req` in the cycle it sees `done`. A `req` still high in the following IDLE cycle is a new transaction.

## Timing
- Reset values:
  - `enable_n` = 1, `din` = 0, `done` = 0, `result` = 0, `status` = 0, both errors = 0, `busy` = 0.
  - State = IDLE, pointer = 1.
- Grant sampled in IDLE at cycle N. `din`/`enable_n` carry bit 0 at N+1 and bit 29 at N+30. `enable_n` returns to 1 at N+31.
- WAIT begins at N+31. Zero-wait response: `dout_valid` at N+31 gives samples at N+31..N+60, DONE at N+61 and `done` visible at N+61.
- Minimum back-to-back spacing: next grant in the IDLE cycle after DONE.
- `rst` mid-transaction aborts. `enable_n` = 1 the cycle after `rst`, no `done` is issued, and the pointer is reset.
- Error flags and `result`/`status` are overwritten only in DONE.

## Test plan
- Single request, requester 0:
  - Stimulus: a0 = 0x0F, b0 = 0x01, op0 = 0x01.
  - Required: `din` stream 0_00001111_0, 0_00000001_1, 1_00000001_0 over N+1..N+30 with `enable_n` = 0.
  - ALU model returns status 0x00 and result 0x0010: `done` = 01, `result` = 0x0010, no errors, done at N+61 with zero wait.
- Simultaneous requests on both requesters, held:
  - Grant order 0, 1, 0, 1 across four transactions.
  - Each `done` is one-hot, and requests are re-raised only after their `done` drops.
- Parity fault: model corrupts data_lsb parity. Required: `done` pulses, `err_parity` = 1, `result` is still the received value.
- Timeout: with `TIMEOUT_CYCLES` = 16 and `dout_valid` never asserted, `done` pulses 16 cycles after WAIT entry with `err_timeout` = 1 and `result` = 0.
- `rst` asserted at frame bit 12:
  - `enable_n` = 1 next cycle, no `done`, `busy` = 0.
  - With both requesters then requesting, requester 0 is granted first.
- `dout_valid` pulsed during SEND then dropped: ignored. A later `dout_valid` with 3-cycle delay completes normally.

Source files
------------

// File: rtl/alu_serial_arbiter.sv
// Round-robin arbiter sharing one serial ALU between two requesters.
// Serializes 30-bit command frames and deserializes checked responses.
module alu_serial_arbiter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [7:0]  a0,
    input  logic [7:0]  b0,
    input  logic [7:0]  op0,
    input  logic [7:0]  a1,
    input  logic [7:0]  b1,
    input  logic [7:0]  op1,
    output logic [1:0]  done,
    output logic [15:0] result,
    output logic [7:0]  status,
    output logic        err_parity,
    output logic        err_timeout,
    output logic        busy,
    output logic        din,
    output logic        enable_n,
    input  logic        dout,
    input  logic        dout_valid
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SEND = 3'd1;
    localparam logic [2:0] WAIT = 3'd2;
    localparam logic [2:0] RECV = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    state;
    logic [4:0]    bcnt;
    logic [TW-1:0] tcnt;
    logic [29:0]   tx_sr;
    logic [28:0]   rx_sr;
    logic          gnt;
    logic          last;

    logic          pick;
    logic [7:0]    sa;
    logic [7:0]    sb;
    logic [7:0]    sop;
    logic [29:0]   frame;
    logic [29:0]   rx_full;
    logic          rx_bad;

    // Winner selection: alternate on contention, else whoever asks
    always_comb begin
        pick = req[1];
        if (req == 2'b11) begin
            pick = ~last;
        end
        sa  = pick ? a1  : a0;
        sb  = pick ? b1  : b0;
        sop = pick ? op1 : op0;
    end

    assign frame = {1'b0, sa, ^sa,
                    1'b0, sb, ^sb,
                    1'b1, sop, ~(^sop)};

    // Full response including the sample taken this cycle
    assign rx_full = {rx_sr, dout};
    assign rx_bad  = ~rx_full[29] | rx_full[19] | rx_full[9]
                   | (^rx_full[29:20])
                   | (^rx_full[19:10])
                   | (^rx_full[9:0]);

    assign busy = (state != IDLE);

    // Transaction sequencer: grant, transmit, await, receive, report
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bcnt        <= 5'd0;
            tcnt        <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            gnt         <= 1'b0;
            last        <= 1'b1;
            din         <= 1'b0;
            enable_n    <= 1'b1;
            done        <= 2'b00;
            result      <= 16'h0000;
            status      <= 8'h00;
            err_parity  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            done <= 2'b00;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        gnt      <= pick;
                        din      <= frame[29];
                        tx_sr    <= {frame[28:0], 1'b0};
                        enable_n <= 1'b0;
                        bcnt     <= 5'd0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (bcnt == 5'd29) begin
                        din      <= 1'b0;
                        enable_n <= 1'b1;
                        tcnt     <= '0;
                        state    <= WAIT;
                    end else begin
                        din   <= tx_sr[29];
                        tx_sr <= {tx_sr[28:0], 1'b0};
                        bcnt  <= bcnt + 5'd1;
                    end
                end
                WAIT: begin
                    if (dout_valid) begin
                        rx_sr <= {rx_sr[27:0], dout};
                        bcnt  <= 5'd1;
                        state <= RECV;
                    end else if (tcnt == TLAST) begin
                        done        <= gnt ? 2'b10 : 2'b01;
                        result      <= 16'h0000;
                        status      <= 8'h00;
                        err_parity  <= 1'b0;
                        err_timeout <= 1'b1;
                        state       <= DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                RECV: begin
                    rx_sr <= {rx_sr[27:0], dout};
                    if (bcnt == 5'd29) begin
                        done        <= gnt ? 2'b10 : 2'b01;
                        status      <= rx_full[28:21];
                        result      <= {rx_full[18:11], rx_full[8:1]};
                        err_parity  <= rx_bad;
                        err_timeout <= 1'b0;
                        state       <= DONE;
                    end else begin
                        bcnt <= bcnt + 5'd1;
                    end
                end
                DONE: begin
                    last  <= gnt;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_arbiter.sv
// Bench for alu_serial_arbiter: transaction-level model, serial ALU
// responder and a per-cycle output comparator.
module tb_alu_serial_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pend;
    logic [7:0]  pa [2];
    logic [7:0]  pb [2];
    logic [7:0]  pop [2];
    logic [1:0]  done;
    logic [15:0] result;
    logic [7:0]  status;
    logic        err_parity, err_timeout, busy, din, enable_n;
    logic        rsp_dout = 1'b0;
    logic        rsp_valid = 1'b0;
    logic        glitch_v = 1'b0;
    logic        dout_valid_w;

    assign dout_valid_w = rsp_valid | glitch_v;

    alu_serial_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .req(pend),
        .a0(pa[0]), .b0(pb[0]), .op0(pop[0]),
        .a1(pa[1]), .b1(pb[1]), .op1(pop[1]),
        .done(done), .result(result), .status(status),
        .err_parity(err_parity), .err_timeout(err_timeout),
        .busy(busy), .din(din), .enable_n(enable_n),
        .dout(rsp_dout), .dout_valid(dout_valid_w)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;
    bit chk_on = 1'b0;

    // model state
    bit          m_last = 1'b1;
    int          plan_mode = 0;
    int          plan_delay = 0;
    bit          plan_hold = 1'b0;
    bit          rec_act = 1'b0;
    int          rec_n, rec_d;
    bit          rec_g;
    logic [29:0] rec_frame;
    logic [15:0] rec_res;
    logic [7:0]  rec_st;
    logic        rec_ep, rec_et;
    logic [15:0] h_res = 16'h0;
    logic [7:0]  h_st = 8'h0;
    logic        h_ep = 1'b0, h_et = 1'b0;

    // captured DUT values for literal checks
    logic [1:0]  cap_done, cap_prev;
    logic [15:0] cap_res;
    logic [7:0]  cap_st;
    logic        cap_ep, cap_et, cap_en, cap_busy;
    logic [29:0] cap_frame;

    function automatic logic [9:0] wrd(input logic t, input logic [7:0] b);
        return {t, b, ^{t, b}};
    endfunction

    function automatic logic [15:0] alu_f(input logic [7:0] a, b, op);
        case (op[1:0])
            2'd0:    return {b, a} ^ 16'h5a5a;
            2'd1:    return {8'h00, a} + {8'h00, b};
            2'd2:    return {8'h00, a} * {8'h00, b};
            default: return {a, b};
        endcase
    endfunction

    function automatic logic [7:0] alu_s(input logic [7:0] a, b, op);
        logic [15:0] r;
        r = alu_f(a, b, op);
        if (op[1:0] == 2'd1) return {7'd0, r[8]};
        return a ^ b ^ op;
    endfunction

    function automatic logic [30:0] pk(input logic bz, en, di,
                                       input logic [1:0] dn,
                                       input logic ep, et,
                                       input logic [7:0] st,
                                       input logic [15:0] rs);
        return {bz, en, di, dn, ep, et, st, rs};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got %h want %h", nm, cyc, act, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic raise(input int i, input logic [7:0] a, b, op);
        pa[i] = a;
        pb[i] = b;
        pop[i] = op;
        pend[i] = 1'b1;
    endtask

    // Runs one transaction from an IDLE cycle; ends in the next IDLE cycle
    task automatic do_txn(input int delay, input int mode, input bit hold,
                          input bit glitch, input bit abort);
        int n, d, g;
        n = cyc;
        g = (pend == 2'b11) ? (m_last ? 0 : 1) : (pend[1] ? 1 : 0);
        plan_mode = mode;
        plan_delay = delay;
        plan_hold = hold;
        rec_n = n;
        rec_g = g[0];
        rec_frame = {wrd(1'b0, pa[g]), wrd(1'b0, pb[g]), wrd(1'b1, pop[g])};
        if (mode == 3) begin
            rec_res = 16'h0; rec_st = 8'h0; rec_ep = 1'b0; rec_et = 1'b1;
            d = n + 31 + 16;
        end else begin
            rec_res = alu_f(pa[g], pb[g], pop[g]);
            rec_st = alu_s(pa[g], pb[g], pop[g]);
            rec_ep = (mode != 0);
            rec_et = 1'b0;
            d = n + 61 + delay;
        end
        rec_d = d;
        rec_act = 1'b1;
        cap_frame = '0;
        cap_prev = 2'b00;
        while (cyc < d) begin
            next_cycle();
            glitch_v = glitch && (cyc == n + 5);
            if (cyc >= n + 1 && cyc <= n + 30) cap_frame = {cap_frame[28:0], din};
            if (cyc == d - 1) cap_prev = done;
            if (abort && cyc == n + 13) begin
                rst = 1'b1;
                next_cycle();
                rst = 1'b0;
                rec_act = 1'b0;
                h_res = 16'h0; h_st = 8'h0; h_ep = 1'b0; h_et = 1'b0;
                m_last = 1'b1;
                cap_done = done;
                cap_en = enable_n;
                cap_busy = busy;
                return;
            end
        end
        cap_done = done;
        cap_res = result;
        cap_st = status;
        cap_ep = err_parity;
        cap_et = err_timeout;
        pend[g] = 1'b0;
        m_last = g[0];
        next_cycle();
        glitch_v = 1'b0;
    endtask

    // Serial ALU model: collects a frame, answers after the planned delay
    initial begin : alu
        int n;
        logic [29:0] fr, rs;
        logic [15:0] r;
        logic [7:0] st;
        n = 0;
        fr = '0;
        forever begin
            @(negedge clk);
            if (!enable_n) begin
                fr = {fr[28:0], din};
                n++;
            end else begin
                n = 0;
            end
            if (n == 30) begin
                n = 0;
                r = alu_f(fr[28:21], fr[18:11], fr[8:1]);
                st = alu_s(fr[28:21], fr[18:11], fr[8:1]);
                rs = {wrd(1'b1, st), wrd(1'b0, r[15:8]), wrd(1'b0, r[7:0])};
                if (plan_mode == 1) rs[0] = ~rs[0];
                if (plan_mode == 2) begin
                    rs[19] = ~rs[19];
                    rs[10] = ~rs[10];
                end
                if (plan_mode != 3) begin
                    repeat (plan_delay + 1) @(posedge clk);
                    #1;
                    for (int j = 29; j >= 0; j--) begin
                        rsp_dout = rs[j];
                        rsp_valid = (j == 29) || plan_hold;
                        @(posedge clk);
                        #1;
                    end
                    rsp_valid = 1'b0;
                    rsp_dout = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model
    initial begin : cmp
        logic [30:0] e, a;
        int k;
        forever begin
            @(negedge clk);
            if (chk_on) begin
                k = cyc;
                e = pk(1'b0, 1'b1, 1'b0, 2'b00, h_ep, h_et, h_st, h_res);
                if (rec_act && k > rec_n) begin
                    if (k <= rec_n + 30)
                        e = pk(1'b1, 1'b0, rec_frame[29 - (k - rec_n - 1)],
                               2'b00, h_ep, h_et, h_st, h_res);
                    else if (k < rec_d)
                        e = pk(1'b1, 1'b1, 1'b0, 2'b00, h_ep, h_et, h_st, h_res);
                    else
                        e = pk(1'b1, 1'b1, 1'b0, rec_g ? 2'b10 : 2'b01,
                               rec_ep, rec_et, rec_st, rec_res);
                end
                a = pk(busy, enable_n, din, done, err_parity, err_timeout,
                       status, result);
                chk("cycle", {1'b0, a}, {1'b0, e});
                if (rec_act && k == rec_d) begin
                    h_res = rec_res; h_st = rec_st;
                    h_ep = rec_ep; h_et = rec_et;
                    rec_act = 1'b0;
                end
            end
        end
    end

    initial begin : main
        int r, mode;
        rst = 1'b1;
        pend = 2'b00;
        for (int i = 0; i < 2; i++) begin
            pa[i] = 8'h0; pb[i] = 8'h0; pop[i] = 8'h0;
        end
        repeat (3) next_cycle();
        rst = 1'b0;
        chk_on = 1'b1;
        chk("rst enable_n", {31'd0, enable_n}, 32'd1);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst outs", {done, err_parity, err_timeout, status, result}, 32'd0);
        next_cycle();

        raise(0, 8'h0F, 8'h01, 8'h01);
        do_txn(0, 0, 1'b1, 1'b0, 1'b0);
        chk("t1 frame", {2'b0, cap_frame}, {2'b0, 30'b0000011110_0000000011_1000000010});
        chk("t1 pre", {30'd0, cap_prev}, 32'd0);
        chk("t1 done", {30'd0, cap_done}, 32'd1);
        chk("t1 result", {16'd0, cap_res}, 32'h0010);
        chk("t1 status/err", {22'd0, cap_st, cap_ep, cap_et}, 32'd0);

        raise(0, 8'h03, 8'h04, 8'h01);
        do_txn(2, 1, 1'b0, 1'b0, 1'b0);
        chk("par done", {30'd0, cap_done}, 32'd1);
        chk("par err", {30'd0, cap_ep, cap_et}, 32'd2);
        chk("par result", {16'd0, cap_res}, 32'h0007);

        raise(1, 8'h55, 8'h66, 8'h02);
        do_txn(0, 3, 1'b0, 1'b0, 1'b0);
        chk("tmo pre", {30'd0, cap_prev}, 32'd0);
        chk("tmo done", {30'd0, cap_done}, 32'd2);
        chk("tmo err", {30'd0, cap_ep, cap_et}, 32'd1);
        chk("tmo result", {16'd0, cap_res}, 32'd0);

        raise(0, 8'h20, 8'h10, 8'h01);
        do_txn(3, 0, 1'b0, 1'b1, 1'b0);
        chk("glitch done", {30'd0, cap_done}, 32'd1);
        chk("glitch err", {30'd0, cap_ep, cap_et}, 32'd0);
        chk("glitch result", {16'd0, cap_res}, 32'h0030);

        raise(1, 8'h05, 8'h06, 8'h02);
        do_txn(15, 0, 1'b1, 1'b0, 1'b0);
        chk("late done", {30'd0, cap_done}, 32'd2);
        chk("late err", {30'd0, cap_ep, cap_et}, 32'd0);
        chk("late result", {16'd0, cap_res}, 32'h001E);

        raise(1, 8'h11, 8'h22, 8'h03);
        do_txn(0, 0, 1'b0, 1'b0, 1'b1);
        chk("abort enable_n", {31'd0, cap_en}, 32'd1);
        chk("abort busy", {31'd0, cap_busy}, 32'd0);
        chk("abort done", {30'd0, cap_done}, 32'd0);

        raise(0, 8'h81, 8'h7F, 8'h01);
        for (int t = 0; t < 4; t++) begin
            do_txn($urandom_range(0, 6), 0, 1'(t), 1'b0, 1'b0);
            chk("rr grant", {30'd0, cap_done}, (t % 2 == 0) ? 32'd1 : 32'd2);
            if (!pend[0]) raise(0, 8'($urandom), 8'($urandom), 8'($urandom));
            if (!pend[1]) raise(1, 8'($urandom), 8'($urandom), 8'($urandom));
        end

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 2; i++)
                if (!pend[i] && $urandom_range(0, 2) != 0)
                    raise(i, 8'($urandom), 8'($urandom), 8'($urandom));
            if (pend == 2'b00)
                raise(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                      8'($urandom));
            r = int'($urandom_range(0, 19));
            mode = (r < 2) ? 3 : (r < 5) ? 1 : (r < 7) ? 2 : 0;
            do_txn(int'($urandom_range(0, 15)), mode, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (3) next_cycle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
